dmem_dump_arbiter: RTL and testbench

Shares the single-port data memory between the CPU load/store port and a built-in memory-dump sequencer. The dump sequencer streams every word of data memory out over a valid/ready port, for bench checking and debug readout. The block sits between the CPU datapath (ALU address, rt write data, controller memRead/memWrite) and the data memory. The CPU has priority. The dump engine uses idle memory cycles, plus a bounded forced slot that stalls the CPU.

---
 rtl/dmem_dump_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_dump_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_arbiter.sv
// dmem_dump_arbiter: shares the single-port data memory between the CPU
// load/store port and a sequencer that streams every memory word out over
// a valid/ready port. The CPU has priority. The dump engine takes idle
// cycles, and after MAX_WAIT denied cycles it forces one slot that stalls
// the CPU.
// Optional feature: define DMEM_DUMP_SKIP_ZERO_EN to skip zero-valued
// words, so that only nonzero words are presented.
module dmem_dump_arbiter #(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        dump_start,
    output logic        dump_busy,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_done
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [IW-1:0] LAST_INDEX = IW'(DEPTH - 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDone} state_e;

    state_e        state;
    logic [IW-1:0] index;
    logic [WW-1:0] wait_cnt;

    logic        cpu_req;
    logic        in_fetch;
    logic        force_slot;
    logic        dump_grant;
    logic        skip_word;
    logic [31:0] index_addr;

    assign cpu_req    = cpu_mem_read | cpu_mem_write;
    assign in_fetch   = (state == StFetch);
    // After MAX_WAIT denied cycles the dump takes the port even against a CPU request.
    assign force_slot = in_fetch && cpu_req && (wait_cnt == WAIT_LIMIT);
    assign dump_grant = in_fetch && (!cpu_req || force_slot);
    assign index_addr = 32'(index) << 2;

`ifdef DMEM_DUMP_SKIP_ZERO_EN
    assign skip_word = (mem_rdata == 32'd0);
`else
    assign skip_word = 1'b0;
`endif

    // Memory port routing: the dump owns the port only in its granted FETCH cycle.
    always_comb begin
        cpu_stall = force_slot;
        mem_read  = cpu_mem_read;
        mem_write = cpu_mem_write;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
        if (dump_grant) begin
            mem_read  = 1'b1;
            mem_write = 1'b0;
            mem_addr  = index_addr;
            mem_wdata = 32'd0;
            cpu_rdata = 32'd0;
        end
    end

    // Dump sequencer FSM with registered status and data outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= StIdle;
            index      <= '0;
            wait_cnt   <= '0;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            dump_addr  <= 32'd0;
            dump_data  <= 32'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (dump_start) begin
                        state     <= StFetch;
                        index     <= '0;
                        wait_cnt  <= '0;
                        dump_busy <= 1'b1;
                    end
                end
                StFetch: begin
                    if (dump_grant) begin
                        wait_cnt <= '0;
                        if (skip_word) begin
                            // Zero word is not presented; move straight on.
                            if (index == LAST_INDEX) begin
                                state     <= StDone;
                                dump_done <= 1'b1;
                            end else begin
                                index <= index + IW'(1);
                            end
                        end else begin
                            dump_data  <= mem_rdata;
                            dump_addr  <= index_addr;
                            dump_valid <= 1'b1;
                            state      <= StHold;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                StHold: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (index == LAST_INDEX) begin
                            state     <= StDone;
                            dump_done <= 1'b1;
                        end else begin
                            index <= index + IW'(1);
                            state <= StFetch;
                        end
                    end
                end
                StDone: begin
                    dump_done <= 1'b0;
                    dump_busy <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Bench for dmem_dump_arbiter: a behavioural data memory, a scoreboard of
// expected dump words popped by a monitor, and directed scenarios.
module tb_dmem_dump_arbiter;

    localparam int DEPTH    = 128;
    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_mem_read = 1'b0;
    logic        cpu_mem_write = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        dump_start = 1'b0;
    logic        dump_busy;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [31:0] dump_addr;
    logic [31:0] dump_data;
    logic        dump_done;

    dmem_dump_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_mem_read  (cpu_mem_read),
        .cpu_mem_write (cpu_mem_write),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .dump_start    (dump_start),
        .dump_busy     (dump_busy),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_addr     (dump_addr),
        .dump_data     (dump_data),
        .dump_done     (dump_done)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   acc_cnt = 0;

    // Behavioural memory: combinational read, write on clock edge, bulk fill.
    logic [31:0] mem [0:DEPTH-1];
    logic        fill_req = 1'b0;
    int          fill_mode = 0;
    assign mem_rdata = mem[mem_addr[8:2]];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (fill_req) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fill_mode == 0) mem[i] <= 32'(i + 1);
                else mem[i] <= (i == 7) ? 32'd5 : 32'd0;
            end
        end else if (mem_write) begin
            mem[mem_addr[8:2]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word.
    exp_t e;
    always @(negedge clock) begin
        if (reset) begin
            if (dump_valid) begin
                check("hold_no_stall", 32'(cpu_stall), 32'd0);
                check("hold_cpu_owns_port", mem_addr, cpu_addr);
            end
            if (dump_valid && dump_ready) begin
                acc_cnt++;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got addr %h, expected none", dump_addr);
                end else begin
                    e = sbq.pop_front();
                    check("word_addr", dump_addr, e.addr);
                    check("word_data", dump_data, e.data);
                end
            end
            if (dump_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input int mode);
        fill_mode = mode;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
    endtask

    task automatic push_all();
        for (int i = 0; i < DEPTH; i++) sbq.push_back({32'(i * 4), 32'(i + 1)});
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < bound) begin
            tick();
            k++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no dump_done, expected one within %0d cycles", name, bound);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int d0;
        int k;
        int hold;
        int stored;
        int a0;
        int exp_acc;

        // Reset state
        fill(0);
        tick();
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_busy", 32'(dump_busy), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        check("rst_data", dump_data, 32'd0);
        check("rst_addr", dump_addr, 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        reset = 1'b1;
        tick();
        tick();
        check("idle_busy", 32'(dump_busy), 32'd0);
        check("idle_mem_read", 32'(mem_read), 32'd0);

        // Full uncontended dump, 2 cycles per word
        push_all();
        dump_ready = 1'b1;
        c0 = cyc;
        start_dump();
        check("lat_fetch_busy", 32'(dump_busy), 32'd1);
        check("lat_fetch_valid", 32'(dump_valid), 32'd0);
        tick();
        check("lat_hold_valid", 32'(dump_valid), 32'd1);
        check("lat_hold_addr", dump_addr, 32'd0);
        wait_done(400, "full_dump");
        check("full_dump_cycles", 32'(done_cyc - c0), 32'(2 * DEPTH + 1));
        check("full_dump_drained", 32'(sbq.size()), 32'd0);
        repeat (3) tick();
        check("done_pulse_once", 32'(done_cnt), 32'd1);
        check("after_done_busy", 32'(dump_busy), 32'd0);

        // Backpressure on word 3, CPU store to 0x010 while holding word 2
        for (int i = 0; i < DEPTH; i++)
            sbq.push_back({32'(i * 4), (i == 4) ? 32'hDEADBEEF : 32'(i + 1)});
        hold = 0;
        stored = 0;
        start_dump();
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < 600) begin
            cpu_mem_write = 1'b0;
            cpu_addr = 32'd0;
            cpu_wdata = 32'd0;
            dump_ready = 1'b1;
            if (dump_valid && dump_addr == 32'h8 && stored == 0) begin
                cpu_mem_write = 1'b1;
                cpu_addr = 32'h10;
                cpu_wdata = 32'hDEADBEEF;
                stored = 1;
            end
            if (dump_valid && dump_addr == 32'hC && hold < 5) begin
                dump_ready = 1'b0;
                hold++;
                check("bp_valid", 32'(dump_valid), 32'd1);
                check("bp_addr", dump_addr, 32'hC);
                check("bp_data", dump_data, 32'd4);
                check("bp_no_mem_read", 32'(mem_read), 32'd0);
            end
            tick();
            k++;
        end
        cpu_mem_write = 1'b0;
        cpu_addr = 32'd0;
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL bp_dump_timeout: got no dump_done, expected one within 600 cycles");
        end
        check("bp_cycles_held", 32'(hold), 32'd5);
        check("bp_store_issued", 32'(stored), 32'd1);
        check("bp_drained", 32'(sbq.size()), 32'd0);

        // Continuous CPU loads: 4 CPU grants then 1 forced dump slot, per word
        fill(0);
        push_all();
        cpu_mem_read = 1'b1;
        cpu_addr = 32'h100;
        dump_ready = 1'b1;
        start_dump();
        for (int j = 0; j < 18; j++) begin
            if (j % 6 == 4) begin
                check("force_stall", 32'(cpu_stall), 32'd1);
                check("force_mem_addr", mem_addr, 32'((j / 6) * 4));
                check("force_mem_read", 32'(mem_read), 32'd1);
                check("force_mem_write", 32'(mem_write), 32'd0);
                check("force_cpu_rdata", cpu_rdata, 32'd0);
            end else begin
                check("cpu_slot_stall", 32'(cpu_stall), 32'd0);
                check("cpu_slot_addr", mem_addr, 32'h100);
                check("cpu_slot_rdata", cpu_rdata, 32'h41);
            end
            tick();
        end
        cpu_mem_read = 1'b0;
        cpu_addr = 32'd0;
        wait_done(400, "contended_dump");
        check("contended_drained", 32'(sbq.size()), 32'd0);

        // Reset while holding word 50 aborts with no dump_done
        for (int i = 0; i < 50; i++) sbq.push_back({32'(i * 4), 32'(i + 1)});
        start_dump();
        k = 0;
        while (!(dump_valid && dump_addr == 32'd200) && k < 300) begin
            tick();
            k++;
        end
        check("reach_word50", dump_addr, 32'd200);
        dump_ready = 1'b0;
        reset = 1'b0;
        d0 = done_cnt;
        tick();
        reset = 1'b1;
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_busy", 32'(dump_busy), 32'd0);
        check("abort_addr", dump_addr, 32'd0);
        repeat (5) tick();
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_drained", 32'(sbq.size()), 32'd0);
        push_all();
        dump_ready = 1'b1;
        start_dump();
        tick();
        check("restart_valid", 32'(dump_valid), 32'd1);
        check("restart_addr", dump_addr, 32'd0);
        wait_done(400, "restart_dump");
        check("restart_drained", 32'(sbq.size()), 32'd0);

        // Sparse memory: only mem[7] = 5
        fill(1);
`ifdef DMEM_DUMP_SKIP_ZERO_EN
        sbq.push_back({32'h1C, 32'd5});
        exp_acc = 1;
`else
        for (int i = 0; i < DEPTH; i++)
            sbq.push_back({32'(i * 4), (i == 7) ? 32'd5 : 32'd0});
        exp_acc = DEPTH;
`endif
        a0 = acc_cnt;
        start_dump();
        wait_done(400, "sparse_dump");
        check("sparse_word_count", 32'(acc_cnt - a0), 32'(exp_acc));
        check("sparse_drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
